// File: rtl/peak_evt_pkg.sv
// -----------------------------------------------------------------------------
// peak_evt_pkg
// Shared types and default widths for the peak event reporter.
//   - peak_evt_t : one event record as stored in the FIFO and shown to the host
//   - state_e    : run-tracking FSM states
// Optional feature macro: PEAK_EVT_TIMEOUT_EN adds the WAIT_LOW state.
// -----------------------------------------------------------------------------
package peak_evt_pkg;

  localparam int DATA_W_C    = 16;
  localparam int IDX_W_C     = 16;
  localparam int DUR_W_C     = 8;
  localparam int MIN_WIDTH_C = 2;
  localparam int DEPTH_C     = 8;
  localparam int MAX_DUR_C   = 32;

  typedef struct packed {
    logic        [IDX_W_C-1:0]  start_idx;
    logic        [DUR_W_C-1:0]  dur;
    logic signed [DATA_W_C-1:0] max;
    logic        [IDX_W_C-1:0]  max_idx;
    logic                       trunc;
  } peak_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_PEAK = 2'd1
`ifdef PEAK_EVT_TIMEOUT_EN
    ,
    ST_WAIT_LOW = 2'd2
`endif
  } state_e;

  // Duration increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [DUR_W_C-1:0] dur_sat_inc(input logic [DUR_W_C-1:0] d);
    logic [DUR_W_C-1:0] r;
    if (d == {DUR_W_C{1'b1}}) begin
      r = d;
    end else begin
      r = d + DUR_W_C'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/peak_evt_fifo.sv
// -----------------------------------------------------------------------------
// peak_evt_fifo
// First-word-fall-through FIFO of peak_evt_t records.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push_i/data_i : write request and record
//   pop_i         : read request (ignored when empty)
//   head_o        : head record, all zeros when empty
//   level_o       : number of stored records
//   empty_o/full_o: status
//   drop_o        : a push was refused (full, no simultaneous pop)
// A push and pop on the same cycle while full both succeed; a push into an
// empty FIFO is never bypassed to the head in the same cycle.
// -----------------------------------------------------------------------------
module peak_evt_fifo
  import peak_evt_pkg::*;
#(
  parameter int DEPTH = DEPTH_C
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  peak_evt_t                data_i,
  input  logic                     pop_i,
  output peak_evt_t                head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

  peak_evt_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == DEPTH_L);
  assign pop_ok_s  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok_s = push_i & (~full_o | pop_ok_s);
  assign drop_o    = push_i & full_o & ~pop_ok_s;
  assign level_o   = level_q;
  assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and level next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + (PTR_W + 1)'(1);
      2'b01:   level_d = level_q - (PTR_W + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Record storage; contents are only observed through a valid level.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/peak_event_reporter.sv
// -----------------------------------------------------------------------------
// peak_event_reporter
// Converts runs of asserted peak_status into event records and queues them.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en                : sample strobe; new_sample/peak_status valid when high
//   new_sample        : signed sample tagged with the current index
//   peak_status       : detector flag for this sample
//   clr_ovf           : clears the sticky overflow flag
//   evt_ready         : host accepts the head record
//   evt_valid         : head record available
//   evt_start_idx/evt_dur/evt_max/evt_max_idx/evt_trunc : head record fields
//   in_peak           : FSM is inside a run
//   fifo_level        : stored records
//   overflow          : sticky, a record was dropped
// Optional feature macro: PEAK_EVT_TIMEOUT_EN (force-close long runs at
// MAX_DUR and wait for peak_status to fall before re-arming).
// -----------------------------------------------------------------------------
module peak_event_reporter
  import peak_evt_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_C,
  parameter int IDX_W      = IDX_W_C,
  parameter int DUR_W      = DUR_W_C,
  parameter int MIN_WIDTH  = MIN_WIDTH_C,
  parameter int DEPTH      = DEPTH_C,
  parameter int MAX_DUR    = MAX_DUR_C
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] new_sample,
  input  logic                         peak_status,
  input  logic                         clr_ovf,
  input  logic                         evt_ready,
  output logic                         evt_valid,
  output logic        [IDX_W-1:0]      evt_start_idx,
  output logic        [DUR_W-1:0]      evt_dur,
  output logic signed [DATA_WIDTH-1:0] evt_max,
  output logic        [IDX_W-1:0]      evt_max_idx,
  output logic                         evt_trunc,
  output logic                         in_peak,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         overflow
);

  localparam logic [DUR_W-1:0] MIN_W_L = DUR_W'(MIN_WIDTH);

  state_e                      state_q, state_d;
  logic        [IDX_W-1:0]     idx_q, idx_d;
  logic        [IDX_W-1:0]     start_q, start_d;
  logic        [DUR_W-1:0]     dur_q, dur_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic        [IDX_W-1:0]     max_idx_q, max_idx_d;
  logic                        ovf_q, ovf_d;

  logic                        push_s;
  peak_evt_t                   rec_s;
  peak_evt_t                   head_s;
  logic                        empty_s;
  logic                        full_s;
  logic                        drop_s;
  logic        [DUR_W-1:0]     dur_inc_s;
  logic                        new_max_s;

  assign dur_inc_s = dur_sat_inc(dur_q);
  assign new_max_s = (new_sample > max_q);

`ifdef PEAK_EVT_TIMEOUT_EN
  localparam logic [DUR_W-1:0] MAX_DUR_L = DUR_W'(MAX_DUR);
`else
  localparam int UNUSED_MAX_DUR_L = MAX_DUR;
`endif

  // Run tracking FSM and record assembly.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start_d   = start_q;
    dur_d     = dur_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    push_s    = 1'b0;
    rec_s     = '{start_idx: start_q, dur: dur_q, max: max_q,
                  max_idx: max_idx_q, trunc: 1'b0};
    if (en) begin
      // Index advances after the current sample has been tagged with it.
      idx_d = idx_q + IDX_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (peak_status) begin
            start_d   = idx_q;
            dur_d     = DUR_W'(1);
            max_d     = new_sample;
            max_idx_d = idx_q;
            state_d   = ST_IN_PEAK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_IN_PEAK: begin
          if (peak_status) begin
            dur_d = dur_inc_s;
            // Strict compare keeps the earliest index on ties.
            if (new_max_s) begin
              max_d     = new_sample;
              max_idx_d = idx_q;
            end else begin
              max_d     = max_q;
              max_idx_d = max_idx_q;
            end
`ifdef PEAK_EVT_TIMEOUT_EN
            if (dur_inc_s == MAX_DUR_L) begin
              // Forced close carries this sample's contribution.
              rec_s   = '{start_idx: start_q, dur: dur_inc_s, max: max_d,
                          max_idx: max_idx_d, trunc: 1'b1};
              push_s  = (dur_inc_s >= MIN_W_L);
              state_d = ST_WAIT_LOW;
            end else begin
              state_d = ST_IN_PEAK;
            end
`else
            state_d = ST_IN_PEAK;
`endif
          end else begin
            // Closing sample is not part of the run.
            push_s  = (dur_q >= MIN_W_L);
            state_d = ST_IDLE;
          end
        end
`ifdef PEAK_EVT_TIMEOUT_EN
        ST_WAIT_LOW: begin
          if (!peak_status) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_LOW;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      idx_d = idx_q;
    end
  end

  // Run tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      start_q   <= '0;
      dur_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      start_q   <= start_d;
      dur_q     <= dur_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
    end
  end

  // Sticky overflow: a new drop wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  peak_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .data_i  (rec_s),
    .pop_i   (evt_ready),
    .head_o  (head_s),
    .level_o (fifo_level),
    .empty_o (empty_s),
    .full_o  (full_s),
    .drop_o  (drop_s)
  );

  logic unused_full_s;
  assign unused_full_s = full_s;

  assign evt_valid     = ~empty_s;
  assign evt_start_idx = head_s.start_idx;
  assign evt_dur       = head_s.dur;
  assign evt_max       = head_s.max;
  assign evt_max_idx   = head_s.max_idx;
`ifdef PEAK_EVT_TIMEOUT_EN
  assign evt_trunc     = head_s.trunc;
`else
  logic unused_trunc_s;
  assign unused_trunc_s = head_s.trunc;
  assign evt_trunc      = 1'b0;
`endif
  assign in_peak       = (state_q != ST_IDLE);
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_peak_event_reporter.sv
module tb_peak_event_reporter;

  localparam int DEPTH     = 8;
  localparam int MIN_WIDTH = 2;

  typedef struct {
    logic        [15:0] start;
    logic        [7:0]  dur;
    logic signed [15:0] mx;
    logic        [15:0] mx_idx;
  } tb_rec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic signed [15:0] new_sample = '0;
  logic               peak_status = 1'b0;
  logic               clr_ovf = 1'b0;
  logic               evt_ready = 1'b0;
  logic               evt_valid;
  logic        [15:0] evt_start_idx;
  logic        [7:0]  evt_dur;
  logic signed [15:0] evt_max;
  logic        [15:0] evt_max_idx;
  logic               evt_trunc;
  logic               in_peak;
  logic        [3:0]  fifo_level;
  logic               overflow;

  int checks = 0;
  int failures = 0;

  // Reference model state
  tb_rec_t            exp_q[$];
  logic signed [15:0] run_s[$];
  logic        [15:0] run_i[$];
  logic        [15:0] m_idx = '0;
  int                 mcount = 0;
  bit                 m_ovf = 0;

  peak_event_reporter dut (
    .clk(clk), .rst(rst), .en(en), .new_sample(new_sample),
    .peak_status(peak_status), .clr_ovf(clr_ovf), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_start_idx(evt_start_idx), .evt_dur(evt_dur),
    .evt_max(evt_max), .evt_max_idx(evt_max_idx), .evt_trunc(evt_trunc),
    .in_peak(in_peak), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event record from the run collected so far: earliest strict maximum.
  function automatic tb_rec_t make_rec();
    tb_rec_t r;
    r.start  = run_i[0];
    r.dur    = (run_s.size() > 255) ? 8'd255 : 8'(run_s.size());
    r.mx     = run_s[0];
    r.mx_idx = run_i[0];
    for (int k = 1; k < run_s.size(); k++) begin
      if (run_s[k] > r.mx) begin
        r.mx     = run_s[k];
        r.mx_idx = run_i[k];
      end
    end
    return r;
  endfunction

  task automatic check_state();
    chk("fifo_level", 32'(fifo_level), 32'(mcount));
    chk("evt_valid", 32'(evt_valid), 32'(mcount > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("in_peak", 32'(in_peak), 32'(run_s.size() > 0));
    chk("evt_trunc", 32'(evt_trunc), 32'd0);
  endtask

  task automatic step(input logic e, input logic p, input logic signed [15:0] s);
    bit pop, push, drop;
    tb_rec_t r;
    en = e; peak_status = p; new_sample = s;
    pop = evt_ready && (mcount > 0);
    push = 0; drop = 0;
    if (e) begin
      if (p) begin
        run_s.push_back(s);
        run_i.push_back(m_idx);
      end else if (run_s.size() > 0) begin
        if (run_s.size() >= MIN_WIDTH) begin
          r = make_rec();
          push = 1;
        end
        run_s.delete();
        run_i.delete();
      end
      m_idx = m_idx + 16'd1;
    end
    if (push) begin
      if (mcount == DEPTH && !pop) drop = 1;
      else begin
        exp_q.push_back(r);
        mcount++;
      end
    end
    if (pop) mcount--;
    if (drop) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; peak_status = 1'b0;
    run_s.delete(); run_i.delete(); exp_q.delete();
    m_idx = '0; mcount = 0; m_ovf = 0;
    @(posedge clk);
    #1;
    check_state();
    chk("rst_start_idx", 32'(evt_start_idx), 32'd0);
    chk("rst_dur", 32'(evt_dur), 32'd0);
    chk("rst_max", 32'(evt_max), 32'd0);
    chk("rst_max_idx", 32'(evt_max_idx), 32'd0);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: compares every handshaked record with the model.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rec_unexpected start=%0d dur=%0d", evt_start_idx, evt_dur);
      end else begin
        tb_rec_t e;
        e = exp_q.pop_front();
        if (evt_start_idx !== e.start || evt_dur !== e.dur ||
            evt_max !== e.mx || evt_max_idx !== e.mx_idx) begin
          failures++;
          $display("FAIL rec actual={%0d,%0d,%0d,%0d} expected={%0d,%0d,%0d,%0d}",
                   evt_start_idx, evt_dur, evt_max, evt_max_idx,
                   e.start, e.dur, e.mx, e.mx_idx);
        end
      end
    end
  end

  initial begin
    logic signed [15:0] basic_v [3];
    logic signed [15:0] tie_v [4];
    logic p;
    basic_v = '{16'sd10, 16'sd40, 16'sd25};
    tie_v   = '{-16'sd5, 16'sd30, 16'sd30, -16'sd100};

    @(negedge clk);
    do_reset();

    // Basic run on idx 3..5
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      step(1'b1, (i >= 3 && i <= 5), (i >= 3 && i <= 5) ? basic_v[i-3] : 16'sd0);

    // Glitch rejection then a 2-sample run at idx 7..8
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b1, (i == 2 || i == 7 || i == 8), 16'(i * 3));

    // Tie and negative values
    do_reset();
    step(1'b1, 1'b0, 16'sd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, tie_v[i]);
    step(1'b1, 1'b0, 16'sd0);

    // Backpressure: nine qualifying runs with no reads
    do_reset();
    evt_ready = 1'b0;
    for (int r = 0; r < 9; r++) begin
      step(1'b1, 1'b1, 16'(r));
      step(1'b1, 1'b1, 16'(100 - r));
      step(1'b1, 1'b0, 16'sd0);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'sd0);
    clr_ovf = 1'b1;
    step(1'b0, 1'b0, 16'sd0);
    clr_ovf = 1'b0;

    // Full FIFO with simultaneous push and pop
    evt_ready = 1'b0;
    for (int r = 0; r < 8; r++) begin
      step(1'b1, 1'b1, 16'(r)); step(1'b1, 1'b1, 16'(r)); step(1'b1, 1'b0, 16'sd0);
    end
    step(1'b1, 1'b1, 16'sd7); step(1'b1, 1'b1, 16'sd9);
    evt_ready = 1'b1;
    step(1'b1, 1'b0, 16'sd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'sd0);

    // en gaps inside a run, then reset mid-run
    step(1'b1, 1'b1, 16'sd5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'sd999);
    step(1'b1, 1'b1, 16'sd6);
    step(1'b1, 1'b0, 16'sd0);
    step(1'b1, 1'b1, 16'sd50);
    step(1'b1, 1'b1, 16'sd60);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'sd0);

    // Randomized traffic
    p = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) p = ~p;
      evt_ready = ($urandom_range(0, 2) != 0);
      clr_ovf   = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 700) == 0) do_reset();
      else step(($urandom_range(0, 4) != 0), p, 16'($urandom));
    end
    clr_ovf = 1'b0;

    // Drain
    evt_ready = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 16'sd0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peak_event_reporter.md
Name: peak_event_reporter

Overview:
- Consumer-side companion to the peak detector. Sits on the detector's output stream: per-sample `new_sample` plus `peak_status`, qualified by `en`.
- Turns runs of asserted `peak_status` into discrete event records: start index, duration, maximum sample, and the index of that maximum.
- Buffers records in an internal FIFO and presents them on a valid/ready interface toward the host/logging side.

Parameters:
- DATA_WIDTH, 16, sample width (signed Q8.8, same as detector).
- IDX_W, 16, sample-index counter width.
- DUR_W, 8, duration field width (saturating).
- MIN_WIDTH, 2, minimum run length (samples) for a run to be reported.
- DEPTH, 8, event FIFO depth (power of two).
- MAX_DUR, 32, forced-close length; used only with PEAK_EVT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  sample strobe (same strobe that drives the detector)
- new_sample  in  DATA_WIDTH  signed sample aligned with peak_status
- peak_status  in  1  detector peak flag for this sample
- clr_ovf  in  1  clears sticky overflow
- evt_ready  in  1  consumer accepts head record
- evt_valid  out  1  head record available
- evt_start_idx  out  IDX_W  index of first sample in run
- evt_dur  out  DUR_W  run length in samples
- evt_max  out  DATA_WIDTH  largest signed sample in run
- evt_max_idx  out  IDX_W  index of evt_max
- evt_trunc  out  1  record closed by timeout (always 0 without macro)
- in_peak  out  1  FSM is inside a run
- fifo_level  out  $clog2(DEPTH)+1  stored records
- overflow  out  1  sticky: a record was dropped

Behaviour:
- Reset (synchronous, active-high): sample index=0, FSM=IDLE, FIFO empty.
  - Outputs: evt_valid=0, in_peak=0, fifo_level=0, overflow=0, evt_trunc=0; record fields read 0.
  - Reset mid-run discards the partial run; no record is emitted.
- Sample index:
  - Increments by 1 on every cycle with `en`=1, after the current sample is tagged.
  - Wraps modulo 2^IDX_W; no flag on wrap.
- Cycles with `en`=0: no state change, apart from FIFO pops and clr_ovf.
- FSM states: IDLE, IN_PEAK, WAIT_LOW (WAIT_LOW only with macro).
  - IDLE, en & peak_status: start=idx, max=sample, max_idx=idx, dur=1, go to IN_PEAK.
  - IN_PEAK, en & peak_status: dur+1, saturating at 2^DUR_W-1.
    - If sample > max (strict signed compare): update max and max_idx. Ties keep the earliest index.
  - IN_PEAK, en & !peak_status: close the run and go to IDLE. The closing sample is not part of the run.
    - If dur >= MIN_WIDTH, push the record.
    - Otherwise discard silently.
- Latency: a pushed record shows evt_valid=1 on the cycle after the closing sample is accepted.
- FIFO: first-word-fall-through; record fields reflect the head whenever evt_valid=1.
  - Pop on evt_valid & evt_ready.
  - Push while full with no pop: record dropped; overflow set and held until clr_ovf.
  - Push and pop in the same cycle when full: both succeed and the level is unchanged.
  - Push and pop in the same cycle when empty: the record is not bypassed and appears next cycle.
  - clr_ovf and a new drop in the same cycle: overflow stays 1.
- in_peak = (state != IDLE).

Optional Feature:
- Macro: PEAK_EVT_TIMEOUT_EN.
- Defined:
  - In IN_PEAK, when dur reaches MAX_DUR on an accepted high sample, push the record with evt_trunc=1 (subject to MIN_WIDTH) and go to WAIT_LOW.
  - WAIT_LOW ignores samples until en & !peak_status, then goes to IDLE.
  - A low sample at exactly MAX_DUR follows the normal close path.
- Undefined:
  - No WAIT_LOW state and no MAX_DUR compare logic.
  - evt_trunc tied 0; runs end only on peak_status low, with dur saturating.

Decomposition:
- Package `peak_evt_pkg` holds:
  - typedef `peak_evt_t`, a packed struct {start_idx, dur, max, max_idx, trunc}.
  - FSM state enum.
  - Width localparams derived from the defaults.
- One sub-module, `peak_evt_fifo`: parameterised synchronous FIFO of `peak_evt_t` with level, full/empty and the push/pop rules above. The FSM and run tracking stay in the top.

Test Plan:
- Basic run: idx 0..9, peak_status high on idx 3..5 with samples 10, 40, 25 → one record {start=3, dur=3, max=40, max_idx=4, trunc=0}; evt_valid rises the cycle after idx 6 is accepted.
- Glitch rejection: single high sample at idx 2 → no record, fifo_level stays 0. A 2-sample run at idx 7..8 → record {start=7, dur=2}.
- Tie and negative values: run samples -5, 30, 30, -100 → max=30, max_idx equals the index of the first 30.
- Backpressure: evt_ready=0, nine qualifying runs → fifo_level=8 and overflow=1; records 1-8 are read out intact and run 9 is absent. Pulsing clr_ovf → overflow=0.
- Reset mid-run and `en` gaps: en low for 3 cycles inside a run leaves dur unchanged. rst asserted mid-run → in_peak=0 next cycle and no record ever appears.
- Timeout (macro defined, MAX_DUR=4): peak_status high for 10 samples from idx 0 → exactly one record {start=0, dur=4, trunc=1}. No further record until peak_status goes low, then a new run is reported normally.
